pdh_dac_ramp: RTL and testbench

//  Downstream DAC output stage for the PDH controller.
//  - Takes per-channel 14-bit signed setpoints from the command decoder over a valid/ready write port.
//  - Slews each channel toward its target at a programmable step and tick rate.
//  - Packs both channels as offset-binary into the 32-bit DAC AXI-Stream word (ch1 in [15:0], ch2 in [31:16]).

---
 rtl/pdh_dac_ramp.sv | 122 ++++++++++++
 tb/tb_pdh_dac_ramp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdh_dac_ramp.sv
// Two-channel DAC slew stage: accepts signed setpoints, ramps each channel toward its
// target at a programmable step/tick rate, and streams both codes as offset-binary lanes.
module pdh_dac_ramp #(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DIV_WIDTH        = 16
) (
    input  logic                               clk,
    input  logic                               rst_ni,
    input  logic                               set_valid_i,
    output logic                               set_ready_o,
    input  logic                               set_ch_i,
    input  logic signed [DAC_DATA_WIDTH-1:0]   set_code_i,
    input  logic        [DAC_DATA_WIDTH-1:0]   step_i,
    input  logic        [DIV_WIDTH-1:0]        div_i,
    output logic        [AXIS_TDATA_WIDTH-1:0] dac_tdata_o,
    output logic                               dac_tvalid_o,
    output logic        [1:0]                  busy_o,
    output logic        [1:0]                  done_o
);

    localparam int DW     = DAC_DATA_WIDTH;
    localparam int LANE_W = AXIS_TDATA_WIDTH / 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t                r_state [2];
    state_t                w_state_nxt [2];
    logic signed [DW-1:0]  r_cur [2];
    logic signed [DW-1:0]  r_tgt [2];
    logic signed [DW-1:0]  w_cur_nxt [2];
    logic signed [DW:0]    w_d [2];
    logic        [DW:0]    w_mag [2];
    logic        [1:0]     r_done;
    logic        [1:0]     w_done_nxt;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic                  w_tick;
    logic                  r_ready;
    logic                  r_tvalid_p0;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata_p0;

    function automatic logic [DW:0] abs_diff(input logic signed [DW:0] d);
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    // Offset-binary: flip the sign bit, zero-pad into the 16-bit lane.
    function automatic logic [LANE_W-1:0] to_offset_bin(input logic signed [DW-1:0] c);
        logic [DW-1:0] ob;
        ob         = c;
        ob[DW-1]   = ~ob[DW-1];
        return {{(LANE_W-DW){1'b0}}, ob};
    endfunction

    assign w_tick = (r_cnt >= div_i);

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_state_nxt[n] = r_state[n];
            w_cur_nxt[n]   = r_cur[n];
            w_done_nxt[n]  = 1'b0;
            w_d[n]   = $signed({r_tgt[n][DW-1], r_tgt[n]}) - $signed({r_cur[n][DW-1], r_cur[n]});
            w_mag[n] = abs_diff(w_d[n]);
            case (r_state[n])
                ST_IDLE: begin
                    if (r_tgt[n] != r_cur[n]) w_state_nxt[n] = ST_RAMP;
                end
                ST_RAMP: begin
                    if (w_tick) begin
                        if (step_i == '0 || w_mag[n] <= {1'b0, step_i}) begin
                            w_cur_nxt[n]   = r_tgt[n];
                            w_done_nxt[n]  = 1'b1;
                            w_state_nxt[n] = ST_IDLE;
                        end else if (w_d[n] < 0) begin
                            w_cur_nxt[n] = r_cur[n] - $signed(step_i);
                        end else begin
                            w_cur_nxt[n] = r_cur[n] + $signed(step_i);
                        end
                    end
                end
                default: w_state_nxt[n] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_done      <= '0;
            r_tvalid_p0 <= 1'b0;
            r_tdata_p0  <= {to_offset_bin('0), to_offset_bin('0)};
            for (int n = 0; n < 2; n++) begin
                r_state[n] <= ST_IDLE;
                r_cur[n]   <= '0;
                r_tgt[n]   <= '0;
            end
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_ready <= 1'b1;
            r_done  <= w_done_nxt;
            for (int n = 0; n < 2; n++) begin
                r_state[n] <= w_state_nxt[n];
                r_cur[n]   <= w_cur_nxt[n];
            end
            // A same-cycle tick above still steps toward the old target.
            if (set_valid_i && r_ready) r_tgt[set_ch_i] <= set_code_i;
            // Output stage p0: one cycle behind cur.
            r_tvalid_p0 <= 1'b1;
            r_tdata_p0  <= {to_offset_bin(r_cur[1]), to_offset_bin(r_cur[0])};
        end
    end

    assign set_ready_o  = r_ready;
    assign dac_tdata_o  = r_tdata_p0;
    assign dac_tvalid_o = r_tvalid_p0;
    assign busy_o       = {r_state[1] == ST_RAMP, r_state[0] == ST_RAMP};
    assign done_o       = r_done;

endmodule

// File: tb/tb_pdh_dac_ramp.sv
// Scoreboard bench for pdh_dac_ramp: expected lane values are queued by the stimulus and
// popped by a monitor whenever a DAC lane changes; timing/flag checks are done inline.
module tb_pdh_dac_ramp;

    logic               clk;
    logic               rst_ni;
    logic               set_valid_i;
    logic               set_ready_o;
    logic               set_ch_i;
    logic signed [13:0] set_code_i;
    logic        [13:0] step_i;
    logic        [15:0] div_i;
    logic        [31:0] dac_tdata_o;
    logic               dac_tvalid_o;
    logic        [1:0]  busy_o;
    logic        [1:0]  done_o;

    int checks = 0;
    int errors = 0;
    int dcnt0  = 0;
    int dcnt1  = 0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    pdh_dac_ramp dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .set_valid_i  (set_valid_i),
        .set_ready_o  (set_ready_o),
        .set_ch_i     (set_ch_i),
        .set_code_i   (set_code_i),
        .step_i       (step_i),
        .div_i        (div_i),
        .dac_tdata_o  (dac_tdata_o),
        .dac_tvalid_o (dac_tvalid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic ch, input logic signed [13:0] code);
        @(posedge clk);
        #1;
        set_valid_i = 1'b1;
        set_ch_i    = ch;
        set_code_i  = code;
        @(posedge clk);
        #1;
        set_valid_i = 1'b0;
    endtask

    task automatic wait_lane(input logic ch, input logic [15:0] v, input int budget);
        int c = 0;
        while ((ch ? dac_tdata_o[31:16] : dac_tdata_o[15:0]) !== v && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL wait_lane ch%0d: timeout, lane %h required %h", ch, 
                     ch ? dac_tdata_o[31:16] : dac_tdata_o[15:0], v);
        end
    endtask

    task automatic wait_done(input logic ch, input int budget);
        int c = 0;
        while (done_o[ch] !== 1'b1 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL wait_done ch%0d: timeout after %0d cycles, done pulse required", ch, c);
        end
    endtask

    task automatic monitor();
        logic [15:0] prev1, prev2, l1, l2;
        prev1 = 16'h2000;
        prev2 = 16'h2000;
        forever begin
            @(negedge clk);
            if (done_o[0] === 1'b1) dcnt0++;
            if (done_o[1] === 1'b1) dcnt1++;
            l1 = dac_tdata_o[15:0];
            l2 = dac_tdata_o[31:16];
            if (l1 !== prev1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch1 lane unexpected change: got %h, no change required", l1);
                end else begin
                    chk("ch1 lane seq", 32'(l1), 32'(q1.pop_front()));
                end
                prev1 = l1;
            end
            if (l2 !== prev2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch2 lane unexpected change: got %h, no change required", l2);
                end else begin
                    chk("ch2 lane seq", 32'(l2), 32'(q2.pop_front()));
                end
                prev2 = l2;
            end
        end
    endtask

    initial begin
        int d0, d1, cyc, lows;
        logic [13:0] c;
        rst_ni      = 1'b0;
        set_valid_i = 1'b0;
        set_ch_i    = 1'b0;
        set_code_i  = '0;
        step_i      = '0;
        div_i       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst tdata", dac_tdata_o, 32'h2000_2000);
        chk("rst tvalid", 32'(dac_tvalid_o), 32'd0);
        chk("rst ready", 32'(set_ready_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        fork
            monitor();
        join_none
        tick(1);
        chk("rel tvalid", 32'(dac_tvalid_o), 32'd1);
        chk("rel ready", 32'(set_ready_o), 32'd1);
        chk("rel tdata", dac_tdata_o, 32'h2000_2000);

        // Jump (step 0, div 0) ch1 to full-scale positive
        d0 = dcnt0;
        q1.push_back(16'h3FFF);
        write(1'b0, 14'sh1FFF);
        tick(3);
        chk("jump lane1 3cyc", 32'(dac_tdata_o[15:0]), 32'h3FFF);
        chk("jump lane2 idle", 32'(dac_tdata_o[31:16]), 32'h2000);
        tick(3);
        chk("jump done count", 32'(dcnt0 - d0), 32'd1);
        chk("jump busy clear", 32'(busy_o), 32'd0);

        // Writing the current value must not start a ramp
        d0 = dcnt0;
        write(1'b0, 14'sh1FFF);
        tick(3);
        chk("same code busy", 32'(busy_o), 32'd0);
        chk("same code done", 32'(dcnt0 - d0), 32'd0);

        // Negative ramp 50 -> -50 by 30
        q1.push_back(16'h2032);
        write(1'b0, 14'sd50);
        tick(4);
        step_i = 14'd30;
        d0 = dcnt0;
        q1.push_back(16'h2014);
        q1.push_back(16'h1FF6);
        q1.push_back(16'h1FD8);
        q1.push_back(16'h1FCE);
        write(1'b0, -14'sd50);
        wait_done(1'b0, 20);
        tick(3);
        chk("neg ramp lane1", 32'(dac_tdata_o[15:0]), 32'h1FCE);
        chk("neg ramp done", 32'(dcnt0 - d0), 32'd1);

        // Slow ramp ch2 0 -> 1000, step 100, tick every 10 cycles
        step_i = 14'd100;
        div_i  = 16'd9;
        d1 = dcnt1;
        for (int k = 1; k <= 10; k++) begin
            c = 14'(k * 100);
            q2.push_back({2'b00, c ^ 14'h2000});
        end
        write(1'b1, 14'sd1000);
        tick(1);
        cyc  = 0;
        lows = 0;
        while (done_o[1] !== 1'b1 && cyc < 150) begin
            if (busy_o[1] !== 1'b1) lows++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("slow ramp duration ok", 32'(cyc >= 91 && cyc <= 100), 32'd1);
        chk("slow ramp busy lows", 32'(lows), 32'd0);
        tick(2);
        chk("slow ramp lane2", 32'(dac_tdata_o[31:16]), 32'h23E8);
        chk("slow ramp done", 32'(dcnt1 - d1), 32'd1);
        chk("slow ramp busy end", 32'(busy_o), 32'd0);

        // Mid-ramp retarget: 0 -> 1000, reversed to 0 at 300
        step_i = '0;
        div_i  = '0;
        q2.push_back(16'h2000);
        write(1'b1, 14'sd0);
        tick(4);
        step_i = 14'd100;
        div_i  = 16'd9;
        d1 = dcnt1;
        q2.push_back(16'h2064);
        q2.push_back(16'h20C8);
        q2.push_back(16'h212C);
        q2.push_back(16'h20C8);
        q2.push_back(16'h2064);
        q2.push_back(16'h2000);
        write(1'b1, 14'sd1000);
        wait_lane(1'b1, 16'h212C, 100);
        chk("retarget no early done", 32'(dcnt1 - d1), 32'd0);
        chk("retarget busy", 32'(busy_o[1]), 32'd1);
        write(1'b1, 14'sd0);
        wait_done(1'b1, 100);
        tick(2);
        chk("retarget lane2", 32'(dac_tdata_o[31:16]), 32'h2000);
        chk("retarget done", 32'(dcnt1 - d1), 32'd1);

        // Reset while both channels ramp
        div_i  = 16'hFFFF;
        step_i = 14'd1;
        write(1'b0, 14'sd1000);
        write(1'b1, -14'sd1000);
        tick(2);
        chk("both busy", 32'(busy_o), 32'd3);
        chk("both busy done", 32'(done_o), 32'd0);
        q1.push_back(16'h2000);
        rst_ni = 1'b0;
        tick(1);
        chk("abort busy", 32'(busy_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);
        chk("abort tdata", dac_tdata_o, 32'h2000_2000);
        chk("abort tvalid", 32'(dac_tvalid_o), 32'd0);
        chk("abort ready", 32'(set_ready_o), 32'd0);
        tick(1);
        rst_ni = 1'b1;
        tick(1);
        chk("re-rel tvalid", 32'(dac_tvalid_o), 32'd1);
        tick(3);
        chk("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);
        chk("post reset idle", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
